ex_mem_pipe: RTL and testbench

Parametrised EX/MEM pipeline stage with a valid/ready handshake, a 2-entry skid buffer, synchronous flush, store byte-enable generation, forwarding taps and a stall-cycle counter. It sits between the EX stage (ALU, operand B) and the MEM stage (data memory). It lets MEM back-pressure EX without losing an instruction, and EX's ready input never depends combinationally on MEM's ready.

---
 rtl/ex_mem_pkg.sv | 49 ++++
 rtl/pipe_skid_buf.sv | 80 ++++++++
 rtl/ex_mem_pipe.sv | 111 +++++++++++
 tb/tb_ex_mem_pipe.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/ex_mem_pkg.sv
// Shared types and helpers for the EX/MEM pipeline stage.
// Payload fields are sized for the widest supported datapath.
package ex_mem_pkg;

  localparam int unsigned MAX_W       = 64;
  localparam int unsigned MAX_RADDR_W = 8;

  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;
  localparam logic [1:0] SZ_D = 2'd3;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    FULL  = 2'd1,
    SKID  = 2'd2
  } pipe_state_e;

  typedef struct packed {
    logic [MAX_W-1:0]       alu_out;
    logic [MAX_W-1:0]       store_data;
    logic [MAX_RADDR_W-1:0] rd;
    logic [2:0]             funct3;
    logic                   reg_write;
    logic                   mem_read;
    logic                   mem_write;
    logic                   mem_to_reg;
  } ex_mem_payload_t;

  // Returns {misaligned, lane_mask}; the mask is zero when misaligned.
  function automatic logic [8:0] byte_en(
    input logic [1:0] sz,
    input logic [2:0] off,
    input logic [3:0] lanes
  );
    logic [3:0] n;
    logic [7:0] m;
    logic       bad;
    unique case (sz)
      SZ_B: begin n = 4'd1; m = 8'h01; end
      SZ_H: begin n = 4'd2; m = 8'h03; end
      SZ_W: begin n = 4'd4; m = 8'h0f; end
      SZ_D: begin n = 4'd8; m = 8'hff; end
    endcase
    bad = (n > lanes) | ((off & (n[2:0] - 3'd1)) != 3'd0);
    byte_en = bad ? 9'h100 : {1'b0, m << off};
  endfunction

endpackage

// File: rtl/pipe_skid_buf.sv
// Two-entry skid buffer with registered ready and synchronous flush.
// Ready never depends combinationally on the downstream ready.
module pipe_skid_buf
  import ex_mem_pkg::*;
#(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush_i,
  input  logic         in_valid_i,
  output logic         in_ready_o,
  input  logic [W-1:0] in_data_i,
  output logic         out_valid_o,
  input  logic         out_ready_i,
  output logic [W-1:0] out_data_o
);

  pipe_state_e  state_q, state_d;
  logic [W-1:0] main_q, main_d;
  logic [W-1:0] skid_q, skid_d;
  logic         rdy_q, rdy_d;
  logic         acc, con;

  assign acc = in_valid_i & rdy_q;
  assign con = out_valid_o & out_ready_i;

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    unique case (state_q)
      EMPTY: if (acc) begin
        main_d  = in_data_i;
        state_d = FULL;
      end
      FULL: begin
        if (acc && con) begin
          main_d = in_data_i;
        end else if (acc) begin
          skid_d  = in_data_i;
          state_d = SKID;
        end else if (con) begin
          state_d = EMPTY;
        end
      end
      SKID: if (con) begin
        main_d  = skid_q;
        state_d = FULL;
      end
      default: state_d = EMPTY;
    endcase
    // Flush drops everything; held data is left as-is.
    if (flush_i) begin
      state_d = EMPTY;
      main_d  = main_q;
      skid_d  = skid_q;
    end
    rdy_d = (state_d != SKID);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= EMPTY;
      main_q  <= '0;
      skid_q  <= '0;
      rdy_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
      rdy_q   <= rdy_d;
    end
  end

  assign in_ready_o  = rdy_q;
  assign out_valid_o = (state_q != EMPTY);
  assign out_data_o  = main_q;

endmodule

// File: rtl/ex_mem_pipe.sv
// EX/MEM stage: skid-buffered payload plus bubble gating, lane
// enables, forwarding taps and a saturating stall counter.
module ex_mem_pipe
  import ex_mem_pkg::*;
#(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned RADDR_W = 5,
  parameter int unsigned CNT_W   = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               flush_i,
  input  logic               in_valid_i,
  output logic               in_ready_o,
  input  logic [WIDTH-1:0]   alu_out_i,
  input  logic [WIDTH-1:0]   store_data_i,
  input  logic [RADDR_W-1:0] rd_i,
  input  logic [2:0]         funct3_i,
  input  logic               reg_write_i,
  input  logic               mem_read_i,
  input  logic               mem_write_i,
  input  logic               mem_to_reg_i,
  output logic               out_valid_o,
  input  logic               out_ready_i,
  output logic [WIDTH-1:0]   alu_out_o,
  output logic [WIDTH-1:0]   store_data_o,
  output logic [RADDR_W-1:0] rd_o,
  output logic [2:0]         funct3_o,
  output logic               reg_write_o,
  output logic               mem_read_o,
  output logic               mem_write_o,
  output logic               mem_to_reg_o,
  output logic [WIDTH/8-1:0] byte_en_o,
  output logic               misaligned_o,
  output logic               fwd_valid_o,
  output logic [RADDR_W-1:0] fwd_rd_o,
  output logic [WIDTH-1:0]   fwd_data_o,
  output logic [CNT_W-1:0]   stall_cnt_o
);

  localparam int unsigned PW    = $bits(ex_mem_payload_t);
  localparam int unsigned LANES = WIDTH / 8;
  localparam int unsigned OFF_W = $clog2(LANES);

  ex_mem_payload_t  in_p, out_p;
  logic             v;
  logic [2:0]       off;
  logic [8:0]       be_r;
  logic             memop;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    in_p            = '0;
    in_p.alu_out    = MAX_W'(alu_out_i);
    in_p.store_data = MAX_W'(store_data_i);
    in_p.rd         = MAX_RADDR_W'(rd_i);
    in_p.funct3     = funct3_i;
    in_p.reg_write  = reg_write_i;
    in_p.mem_read   = mem_read_i;
    in_p.mem_write  = mem_write_i;
    in_p.mem_to_reg = mem_to_reg_i;
  end

  pipe_skid_buf #(.W(PW)) u_buf (
    .clk         (clk),
    .rst         (rst),
    .flush_i     (flush_i),
    .in_valid_i  (in_valid_i),
    .in_ready_o  (in_ready_o),
    .in_data_i   (in_p),
    .out_valid_o (v),
    .out_ready_i (out_ready_i),
    .out_data_o  (out_p)
  );

  assign out_valid_o  = v;
  assign alu_out_o    = out_p.alu_out[WIDTH-1:0];
  assign store_data_o = out_p.store_data[WIDTH-1:0];
  assign rd_o         = out_p.rd[RADDR_W-1:0];
  assign funct3_o     = out_p.funct3;

  assign reg_write_o  = v & out_p.reg_write;
  assign mem_read_o   = v & out_p.mem_read;
  assign mem_write_o  = v & out_p.mem_write;
  assign mem_to_reg_o = v & out_p.mem_to_reg;

  assign off   = 3'(out_p.alu_out[OFF_W-1:0]);
  assign be_r  = byte_en(out_p.funct3[1:0], off, 4'(LANES));
  assign memop = out_p.mem_read | out_p.mem_write;

  assign misaligned_o = v & memop & be_r[8];
  assign byte_en_o    = v ? be_r[LANES-1:0] : '0;

  assign fwd_valid_o = v & out_p.reg_write & (rd_o != '0);
  assign fwd_rd_o    = rd_o;
  assign fwd_data_o  = alu_out_o;

  always_comb begin
    cnt_d = cnt_q;
    if (in_valid_i && !in_ready_o && !(&cnt_q))
      cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign stall_cnt_o = cnt_q;

endmodule

// File: tb/tb_ex_mem_pipe.sv
// Scoreboard bench for ex_mem_pipe (WIDTH=32, CNT_W=4).
// Expected outputs are derived from the queued accepted instructions.
module tb_ex_mem_pipe;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush_i = 1'b0;
  logic        in_valid_i = 1'b0;
  logic        in_ready_o;
  logic [31:0] alu_out_i = '0;
  logic [31:0] store_data_i = '0;
  logic [4:0]  rd_i = '0;
  logic [2:0]  funct3_i = '0;
  logic        reg_write_i = 1'b0;
  logic        mem_read_i = 1'b0;
  logic        mem_write_i = 1'b0;
  logic        mem_to_reg_i = 1'b0;
  logic        out_valid_o;
  logic        out_ready_i = 1'b0;
  logic [31:0] alu_out_o, store_data_o, fwd_data_o;
  logic [4:0]  rd_o, fwd_rd_o;
  logic [2:0]  funct3_o;
  logic        reg_write_o, mem_read_o, mem_write_o, mem_to_reg_o;
  logic [3:0]  byte_en_o;
  logic        misaligned_o, fwd_valid_o;
  logic [3:0]  stall_cnt_o;

  ex_mem_pipe #(.WIDTH(32), .RADDR_W(5), .CNT_W(4)) dut (
    .clk          (clk),
    .rst          (rst),
    .flush_i      (flush_i),
    .in_valid_i   (in_valid_i),
    .in_ready_o   (in_ready_o),
    .alu_out_i    (alu_out_i),
    .store_data_i (store_data_i),
    .rd_i         (rd_i),
    .funct3_i     (funct3_i),
    .reg_write_i  (reg_write_i),
    .mem_read_i   (mem_read_i),
    .mem_write_i  (mem_write_i),
    .mem_to_reg_i (mem_to_reg_i),
    .out_valid_o  (out_valid_o),
    .out_ready_i  (out_ready_i),
    .alu_out_o    (alu_out_o),
    .store_data_o (store_data_o),
    .rd_o         (rd_o),
    .funct3_o     (funct3_o),
    .reg_write_o  (reg_write_o),
    .mem_read_o   (mem_read_o),
    .mem_write_o  (mem_write_o),
    .mem_to_reg_o (mem_to_reg_o),
    .byte_en_o    (byte_en_o),
    .misaligned_o (misaligned_o),
    .fwd_valid_o  (fwd_valid_o),
    .fwd_rd_o     (fwd_rd_o),
    .fwd_data_o   (fwd_data_o),
    .stall_cnt_o  (stall_cnt_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] alu;
    logic [31:0] sd;
    logic [4:0]  rd;
    logic [2:0]  f3;
    logic        rw, mr, mw, m2r;
  } item_t;

  item_t q[$];
  int    checks = 0;
  int    errors = 0;
  int    scnt = 0;
  bit    after_rst = 1'b0;

  task automatic chk(input string n, input logic [63:0] a,
                     input logic [63:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s got %0h want %0h", n, a, e);
    end
  endtask

  always @(negedge clk) begin
    item_t h;
    item_t n;
    int    sz;
    int    offs;
    bit    bad;
    logic [3:0] be;
    chk("in_ready", in_ready_o, after_rst ? (q.size() < 2) : 1'b0);
    chk("out_valid", out_valid_o, q.size() > 0);
    chk("stall_cnt", stall_cnt_o, scnt);
    if (q.size() > 0) begin
      h    = q[0];
      sz   = 1 << h.f3[1:0];
      offs = h.alu % 4;
      bad  = (sz > 4) || ((h.alu % sz) != 0);
      be   = bad ? 4'h0 : 4'(((1 << sz) - 1) << offs);
      chk("alu_out", alu_out_o, h.alu);
      chk("store_data", store_data_o, h.sd);
      chk("rd", rd_o, h.rd);
      chk("funct3", funct3_o, h.f3);
      chk("ctl", {reg_write_o, mem_read_o, mem_write_o, mem_to_reg_o},
          {h.rw, h.mr, h.mw, h.m2r});
      chk("byte_en", byte_en_o, be);
      chk("misaligned", misaligned_o, (h.mr || h.mw) && bad);
      chk("fwd_valid", fwd_valid_o, h.rw && (h.rd != 0));
      chk("fwd_rd", fwd_rd_o, h.rd);
      chk("fwd_data", fwd_data_o, h.alu);
    end else begin
      chk("bubble", {reg_write_o, mem_read_o, mem_write_o, mem_to_reg_o,
                     fwd_valid_o, misaligned_o, byte_en_o}, '0);
    end
    if (q.size() > 0 && out_valid_o && out_ready_i) void'(q.pop_front());
    if (in_valid_i && in_ready_o && !flush_i && !rst) begin
      n.alu = alu_out_i;  n.sd = store_data_i;
      n.rd = rd_i;        n.f3 = funct3_i;
      n.rw = reg_write_i; n.mr = mem_read_i;
      n.mw = mem_write_i; n.m2r = mem_to_reg_i;
      q.push_back(n);
    end
    if (rst || flush_i) q.delete();
    if (rst) scnt = 0;
    else if (in_valid_i && !in_ready_o && scnt < 15) scnt++;
    after_rst = !rst;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic v, input logic [31:0] a,
                      input logic [4:0] r, input logic [2:0] f,
                      input logic [3:0] ctl, input logic ordy);
    in_valid_i   = v;
    alu_out_i    = a;
    store_data_i = $urandom;
    rd_i         = r;
    funct3_i     = f;
    {reg_write_i, mem_read_i, mem_write_i, mem_to_reg_i} = ctl;
    out_ready_i  = ordy;
    tick();
  endtask

  initial begin
    logic [2:0] f;
    rst = 1'b1;
    tick();
    tick();
    chk("rst_valid", out_valid_o, 1'b0);
    chk("rst_cnt", stall_cnt_o, 4'h0);
    rst = 1'b0;
    send(0, 0, 0, 0, 4'b0000, 1);
    send(1, 32'h10, 5, 3'b010, 4'b1000, 1);
    chk("tp_valid", out_valid_o, 1'b1);
    chk("tp_alu", alu_out_o, 32'h10);
    chk("tp_fwd", {fwd_valid_o, fwd_rd_o}, {1'b1, 5'd5});
    send(0, 0, 0, 0, 4'b0000, 1);
    send(1, 32'h1, 1, 3'b010, 4'b1000, 0);
    send(1, 32'h2, 2, 3'b010, 4'b1000, 0);
    chk("skid_ready", in_ready_o, 1'b0);
    chk("skid_hold", alu_out_o, 32'h1);
    send(1, 32'h3, 3, 3'b010, 4'b1000, 0);
    send(0, 0, 0, 0, 4'b0000, 1);
    chk("drain_b", alu_out_o, 32'h2);
    send(0, 0, 0, 0, 4'b0000, 1);
    send(1, 32'h4, 4, 3'b010, 4'b1000, 0);
    send(1, 32'h5, 6, 3'b010, 4'b1000, 0);
    flush_i = 1'b1;
    send(1, 32'hC, 7, 3'b010, 4'b1000, 0);
    flush_i = 1'b0;
    chk("flush_valid", out_valid_o, 1'b0);
    chk("flush_ready", in_ready_o, 1'b1);
    send(1, 32'h6, 1, 3'b001, 4'b0010, 0);
    chk("st_be", {misaligned_o, byte_en_o}, {1'b0, 4'b1100});
    send(1, 32'h5, 1, 3'b001, 4'b0010, 1);
    chk("st_mis", {misaligned_o, byte_en_o}, {1'b1, 4'b0000});
    send(1, 32'h20, 0, 3'b010, 4'b1000, 1);
    chk("rd0_fwd", fwd_valid_o, 1'b0);
    send(1, 32'h8, 3, 3'b011, 4'b1101, 1);
    chk("ld_d_mis", misaligned_o, 1'b1);
    send(0, 0, 0, 0, 4'b0000, 1);
    repeat (19) send(1, $urandom, 5'($urandom), 3'b010, 4'b1000, 0);
    chk("sat_cnt", stall_cnt_o, 4'hF);
    rst = 1'b1;
    tick();
    chk("rst_mid_cnt", stall_cnt_o, 4'h0);
    chk("rst_mid_valid", out_valid_o, 1'b0);
    rst = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      f = 3'($urandom_range(0, 6));
      flush_i = ($urandom_range(0, 99) < 3);
      rst = ($urandom_range(0, 99) < 1);
      send($urandom_range(0, 9) < 7, $urandom, 5'($urandom_range(0, 7)),
           f, 4'($urandom), $urandom_range(0, 9) < 6);
    end
    flush_i = 1'b0;
    rst = 1'b0;
    repeat (5) send(0, 0, 0, 0, 4'b0000, 1);
    chk("drain_empty", q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
